pkt_sg_writer: RTL and testbench
================================

PKT_SG_WRITER -- requirements
Module: pkt_sg_writer

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, data word width; ADDR_W, default 12, block address width; BLK_WORDS, default 8, words per memory block; LEN_W, default 4, block-count field width (max 2^LEN_W blocks); PRI_W, default 3, priority width; PORT_W, default 4, destination port width.
REQ-002 SHALL have ports (name, direction, width, meaning):
iClk  in  1  single clock, rising edge.
iRst_n  in  1  reset, asynchronous, active-low.
iSop, iEop, iVld  in  1  input stream start, end and valid.
iData  in  DATA_W  input word.
oRdy  out  1  input stream ready.
iEptyAddr  in  ADDR_W  free block address.
iEptyAddrVld  in  1  free address valid.
oEptyAddrRdy  out  1  free address accept.
oPktData  out  DATA_W  word to MMU.
oPktAddr  out  ADDR_W  block address of oPktData.
oPktDataVld  out  1  MMU write valid.
oPktWrLast  out  1  last word of block.
iMmuRdy  in  1  MMU ready.
oLaddr, oLdata  out  ADDR_W  link-list entry (current block, next block).
oLaddrVld  out  1  link write strobe, one cycle.
oTagFirAddr  out  ADDR_W  first block address.
oTagLen  out  LEN_W  block count minus 1.
oTagPri  out  PRI_W  packet priority.
oTagDstPort  out  PORT_W  destination port.
oTagErr  out  1  packet truncated.
oTagVld  out  1  tag valid.
iTagRdy  in  1  tag accept.

Function
REQ-003 SHALL implement an FSM with states IDLE, GET_ADDR, WRITE, DRAIN and TAG.
REQ-004 In IDLE, oRdy SHALL be 0 when iVld&&iSop; words with iVld&&!iSop SHALL be accepted (oRdy=1) and discarded. iVld&&iSop SHALL move the FSM to GET_ADDR without consuming the word.
REQ-005 In GET_ADDR, oEptyAddrRdy SHALL be 1. The transfer SHALL occur when iEptyAddrVld&&oEptyAddrRdy. On the transfer, the FSM SHALL capture the address as the current block and clear the word counter.
REQ-006 At that transfer, for the first block of a packet, the address SHALL be latched as oTagFirAddr. For any later block, the block SHALL pulse oLaddrVld for one cycle with oLaddr = previous block address and oLdata = new address. The FSM SHALL then move to WRITE.
REQ-007 In WRITE, oRdy SHALL be (!oPktDataVld || iMmuRdy). An accepted word SHALL be registered into oPktData and oPktAddr with oPktDataVld=1 on the next cycle (1-cycle latency).
REQ-008 oPktDataVld and its data SHALL hold stable until iMmuRdy. oPktDataVld SHALL clear after a transfer when no new word was accepted in the same cycle.
REQ-009 On the first word of a packet, the block SHALL latch oTagDstPort=iData[PORT_W-1:0] and oTagPri=iData[PORT_W+PRI_W-1:PORT_W].
REQ-010 An accepted word with iEop SHALL set oPktWrLast for that word, and the FSM SHALL go to TAG. This applies even when the word is also at the block boundary: no further address is requested.
REQ-011 An accepted word without iEop at word count BLK_WORDS-1 SHALL set oPktWrLast. It SHALL also increment the block count. The FSM SHALL go to GET_ADDR, or to DRAIN if the block count is already 2^LEN_W-1.
REQ-012 In DRAIN, oRdy SHALL be 1 and words SHALL be discarded. The error flag SHALL be set. The word with iEop SHALL move the FSM to TAG.
REQ-013 iSop seen after the first word of a packet SHALL be treated as data.
REQ-014 In TAG, oRdy SHALL be 0. oTagVld SHALL assert only once oPktDataVld is 0, carrying oTagLen = block count minus 1 and oTagErr. oTagVld SHALL hold until iTagRdy, then the FSM SHALL return to IDLE and clear the error and block count.
REQ-015 Word counter width SHALL be clog2(BLK_WORDS). The block counter SHALL be LEN_W bits and SHALL never wrap.

Reset
REQ-016 While iRst_n=0, the FSM SHALL be IDLE, counters and the error flag SHALL be 0, and every output SHALL be 0.
REQ-017 Reset asserted mid-packet SHALL abandon the packet with no tag and no further link write. The block SHALL restart from IDLE after release.

Verification (BLK_WORDS=8, LEN_W=4)
REQ-018 3-word packet, address 0x005 -> 3 MMU writes to 0x005; WrLast on word 3; no oLaddrVld; tag FirAddr=0x005, Len=0, Err=0.
REQ-019 20-word packet, addresses 0x010/0x011/0x012 -> links (0x010->0x011) and (0x011->0x012); WrLast on words 8, 16 and 20; Len=2.
REQ-020 8-word packet -> exactly one address consumed (oEptyAddrRdy not re-asserted); Len=0.
REQ-021 iMmuRdy held low 5 cycles mid-block -> oPktData/oPktAddr stable, oRdy=0, no word lost or duplicated; a tag offered with iTagRdy=0 holds until accepted.
REQ-022 130-word packet -> 16 blocks written (128 words), Len=15, Err=1; words 129-130 discarded; 16 addresses consumed.
REQ-023 Reset after 5 words of a packet, then a 3-word packet -> the first packet produces no tag; the second produces a correct tag with Len=0.

Source files
------------

// File: rtl/pkt_sg_writer.sv
// Scatter-gather packet writer: splits an input packet stream into fixed-size
// memory blocks, links the blocks into a list and emits one tag per packet.
module pkt_sg_writer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int BLK_WORDS = 8,
  parameter int LEN_W     = 4,
  parameter int PRI_W     = 3,
  parameter int PORT_W    = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iSop,
  input  logic              iEop,
  input  logic              iVld,
  input  logic [DATA_W-1:0] iData,
  output logic              oRdy,
  input  logic [ADDR_W-1:0] iEptyAddr,
  input  logic              iEptyAddrVld,
  output logic              oEptyAddrRdy,
  output logic [DATA_W-1:0] oPktData,
  output logic [ADDR_W-1:0] oPktAddr,
  output logic              oPktDataVld,
  output logic              oPktWrLast,
  input  logic              iMmuRdy,
  output logic [ADDR_W-1:0] oLaddr,
  output logic [ADDR_W-1:0] oLdata,
  output logic              oLaddrVld,
  output logic [ADDR_W-1:0] oTagFirAddr,
  output logic [LEN_W-1:0]  oTagLen,
  output logic [PRI_W-1:0]  oTagPri,
  output logic [PORT_W-1:0] oTagDstPort,
  output logic              oTagErr,
  output logic              oTagVld,
  input  logic              iTagRdy
);

  localparam int WCNT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BLK_WORDS - 1);
  localparam logic [LEN_W-1:0]  MAX_BLK   = '1;

  typedef enum logic [2:0] {IDLE, GET_ADDR, WRITE, DRAIN, TAG} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr;
  logic [WCNT_W-1:0]   word_cnt;
  logic [LEN_W-1:0]    blk_cnt;
  logic                err;
  logic                first_word;
  logic                rdy;
  logic                addr_rdy;
  logic                word_take;
  logic                addr_take;
  logic                tag_vld;
  logic                blk_end;

  assign tag_vld   = (state == TAG) && !oPktDataVld;
  assign word_take = (state == WRITE) && iVld && rdy;
  assign addr_take = addr_rdy && iEptyAddrVld;
  assign blk_end   = (word_cnt == LAST_WORD);

  // Ready is gated by reset so that every output reads 0 while held in reset.
  assign oRdy         = rdy & iRst_n;
  assign oEptyAddrRdy = addr_rdy;
  assign oTagVld      = tag_vld;
  assign oTagLen      = blk_cnt;
  assign oTagErr      = err;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    addr_rdy  = 1'b0;
    case (state)
      IDLE: begin
        rdy = !iSop;
        if (iVld && iSop) state_nxt = GET_ADDR;
      end
      GET_ADDR: begin
        addr_rdy = 1'b1;
        if (iEptyAddrVld) state_nxt = WRITE;
      end
      WRITE: begin
        rdy = !oPktDataVld || iMmuRdy;
        if (iVld && rdy) begin
          if (iEop)         state_nxt = TAG;
          else if (blk_end) state_nxt = (blk_cnt == MAX_BLK) ? DRAIN : GET_ADDR;
        end
      end
      DRAIN: begin
        rdy = 1'b1;
        if (iVld && iEop) state_nxt = TAG;
      end
      TAG: begin
        if (tag_vld && iTagRdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // blk_cnt holds the index of the current block, so it already equals the
  // tag length field; it saturates at MAX_BLK and the overflow goes to DRAIN.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cur_addr    <= '0;
      word_cnt    <= '0;
      blk_cnt     <= '0;
      err         <= 1'b0;
      first_word  <= 1'b0;
      oPktData    <= '0;
      oPktAddr    <= '0;
      oPktDataVld <= 1'b0;
      oPktWrLast  <= 1'b0;
      oLaddr      <= '0;
      oLdata      <= '0;
      oLaddrVld   <= 1'b0;
      oTagFirAddr <= '0;
      oTagPri     <= '0;
      oTagDstPort <= '0;
    end else begin
      oLaddrVld <= 1'b0;
      if (state == IDLE) first_word <= 1'b1;

      if (addr_take) begin
        cur_addr <= iEptyAddr;
        word_cnt <= '0;
        if (blk_cnt == '0) begin
          oTagFirAddr <= iEptyAddr;
        end else begin
          oLaddrVld <= 1'b1;
          oLaddr    <= cur_addr;
          oLdata    <= iEptyAddr;
        end
      end

      if (word_take) begin
        oPktData    <= iData;
        oPktAddr    <= cur_addr;
        oPktDataVld <= 1'b1;
        oPktWrLast  <= iEop || blk_end;
        word_cnt    <= word_cnt + 1'b1;
        first_word  <= 1'b0;
        if (first_word) begin
          oTagDstPort <= iData[PORT_W-1:0];
          oTagPri     <= iData[PORT_W+PRI_W-1:PORT_W];
        end
        if (!iEop && blk_end) begin
          if (blk_cnt == MAX_BLK) err <= 1'b1;
          else                    blk_cnt <= blk_cnt + 1'b1;
        end
      end else if (oPktDataVld && iMmuRdy) begin
        oPktDataVld <= 1'b0;
        oPktWrLast  <= 1'b0;
      end

      if (state == DRAIN) err <= 1'b1;

      if (tag_vld && iTagRdy) begin
        err     <= 1'b0;
        blk_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_sg_writer.sv
// Scoreboard bench for pkt_sg_writer: directed packets push expected MMU
// writes, link entries and tags; negedge monitors pop and compare them.
module tb_pkt_sg_writer;

  localparam int DATA_W = 32, ADDR_W = 12, BLK_WORDS = 8, LEN_W = 4, PRI_W = 3, PORT_W = 4;

  logic              iClk, iRst_n;
  logic              iSop, iEop, iVld;
  logic [DATA_W-1:0] iData;
  logic              oRdy;
  logic [ADDR_W-1:0] iEptyAddr;
  logic              iEptyAddrVld, oEptyAddrRdy;
  logic [DATA_W-1:0] oPktData;
  logic [ADDR_W-1:0] oPktAddr;
  logic              oPktDataVld, oPktWrLast, iMmuRdy;
  logic [ADDR_W-1:0] oLaddr, oLdata;
  logic              oLaddrVld;
  logic [ADDR_W-1:0] oTagFirAddr;
  logic [LEN_W-1:0]  oTagLen;
  logic [PRI_W-1:0]  oTagPri;
  logic [PORT_W-1:0] oTagDstPort;
  logic              oTagErr, oTagVld, iTagRdy;

  pkt_sg_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_WORDS(BLK_WORDS),
    .LEN_W(LEN_W), .PRI_W(PRI_W), .PORT_W(PORT_W)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iSop(iSop), .iEop(iEop), .iVld(iVld),
    .iData(iData), .oRdy(oRdy), .iEptyAddr(iEptyAddr), .iEptyAddrVld(iEptyAddrVld),
    .oEptyAddrRdy(oEptyAddrRdy), .oPktData(oPktData), .oPktAddr(oPktAddr),
    .oPktDataVld(oPktDataVld), .oPktWrLast(oPktWrLast), .iMmuRdy(iMmuRdy),
    .oLaddr(oLaddr), .oLdata(oLdata), .oLaddrVld(oLaddrVld),
    .oTagFirAddr(oTagFirAddr), .oTagLen(oTagLen), .oTagPri(oTagPri),
    .oTagDstPort(oTagDstPort), .oTagErr(oTagErr), .oTagVld(oTagVld), .iTagRdy(iTagRdy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  int addrIdx = 0;
  int addrsUsed = 0;
  int mmuWrites = 0;
  int pktNum = 0;
  bit ignoreMon = 1'b0;

  logic [44:0] mmuQ[$];
  logic [23:0] linkQ[$];
  logic [23:0] tagQ[$];
  logic [ADDR_W-1:0] addrs[0:31];

  logic [97:0] allOut;
  assign allOut = {oRdy, oEptyAddrRdy, oPktData, oPktAddr, oPktDataVld, oPktWrLast,
                   oLaddr, oLdata, oLaddrVld, oTagFirAddr, oTagLen, oTagPri,
                   oTagDstPort, oTagErr, oTagVld};

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event not seen within cycle budget", name);
  endtask

  function automatic logic [31:0] wordOf(input int p, input int k, input logic [6:0] hdr);
    return {8'(p + 8'hA0), 8'h00, 9'(k), hdr};
  endfunction

  // Monitors: every transfer the DUT presents is popped and compared.
  always @(negedge iClk) begin
    if (iRst_n) begin
      if (oPktDataVld && iMmuRdy) begin
        mmuWrites++;
        if (!ignoreMon) begin
          if (mmuQ.size() == 0) failNow("mmu_unexpected_write");
          else checkOutput("mmu_word", {oPktData, oPktAddr, oPktWrLast}, mmuQ.pop_front());
        end
      end
      if (oLaddrVld) begin
        if (linkQ.size() == 0) failNow("link_unexpected");
        else checkOutput("link", {oLaddr, oLdata}, linkQ.pop_front());
      end
      if (oTagVld && iTagRdy) begin
        if (tagQ.size() == 0) failNow("tag_unexpected");
        else checkOutput("tag", {oTagFirAddr, oTagLen, oTagPri, oTagDstPort, oTagErr}, tagQ.pop_front());
      end
    end
  end

  // Free-address source: always valid, advances one entry per accepted address.
  initial begin
    for (int i = 0; i < 32; i++) addrs[i] = 12'h3FF;
    addrs[0] = 12'h005;
    addrs[1] = 12'h010; addrs[2] = 12'h011; addrs[3] = 12'h012;
    addrs[4] = 12'h020;
    addrs[5] = 12'h030;
    for (int i = 6; i < 22; i++) addrs[i] = 12'(12'h100 + i - 6);
    addrs[22] = 12'h200;
    addrs[23] = 12'h201;
    iEptyAddr = addrs[0];
    iEptyAddrVld = 1'b1;
    forever begin
      @(negedge iClk);
      if (oEptyAddrRdy && iEptyAddrVld) begin
        @(posedge iClk);
        #1;
        addrIdx++;
        addrsUsed++;
        iEptyAddr = addrs[addrIdx];
      end
    end
  end

  task automatic driveWord(input logic [31:0] d, input bit sop, input bit eop);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    iVld = 1'b1; iData = d; iSop = sop; iEop = eop;
    while (!acc && t < 200) begin
      @(negedge iClk);
      acc = oRdy;
      @(posedge iClk);
      #1;
      t++;
    end
    if (!acc) failNow("word_accept");
    iVld = 1'b0; iSop = 1'b0; iEop = 1'b0;
  endtask

  task automatic stallMmu(input int mw0);
    int t;
    logic [43:0] held;
    t = 0;
    while (!(mmuWrites >= mw0 + 2 && oPktDataVld) && t < 200) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 200) failNow("stall_start");
    @(posedge iClk);
    #1;
    iMmuRdy = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      if (i == 0) held = {oPktData, oPktAddr};
      else checkOutput("stall_data_stable", {oPktData, oPktAddr}, held);
      checkOutput("stall_rdy_low", oRdy, 0);
      checkOutput("stall_vld_high", oPktDataVld, 1);
    end
    @(posedge iClk);
    #1;
    iMmuRdy = 1'b1;
  endtask

  task automatic holdTag();
    int t;
    logic [16:0] held;
    t = 0;
    while (!oTagVld && t < 600) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 600) failNow("tag_offer");
    held = {oTagFirAddr, oTagLen, oTagErr};
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      checkOutput("tag_hold_vld", oTagVld, 1);
      checkOutput("tag_hold_fields", {oTagFirAddr, oTagLen, oTagErr}, held);
      checkOutput("tag_rdy_low", oRdy, 0);
    end
    @(posedge iClk);
    #1;
    iTagRdy = 1'b1;
  endtask

  // Issues one packet; expected tag length, error and address count are hand-supplied.
  task automatic applyStimulus(input int n, input logic [6:0] hdr, input logic [3:0] expLen,
                               input logic expErr, input int expAddrs, input bit stall,
                               input int sopAt);
    int start, used0, nblk, t, mw0;
    start = addrIdx;
    used0 = addrsUsed;
    mw0 = mmuWrites;
    for (int k = 0; k < n; k++)
      if (k < 128)
        mmuQ.push_back({wordOf(pktNum, k, hdr), addrs[start + k / 8], ((k % 8) == 7) || (k == n - 1)});
    nblk = (n + 7) / 8;
    if (nblk > 16) nblk = 16;
    for (int b = 1; b < nblk; b++) linkQ.push_back({addrs[start + b - 1], addrs[start + b]});
    tagQ.push_back({addrs[start], expLen, hdr[6:4], hdr[3:0], expErr});
    if (stall) iTagRdy = 1'b0;
    fork
      for (int k = 0; k < n; k++) driveWord(wordOf(pktNum, k, hdr), (k == 0) || (k == sopAt), k == n - 1);
      if (stall) stallMmu(mw0);
      if (stall) holdTag();
    join
    t = 0;
    while ((tagQ.size() != 0 || mmuQ.size() != 0 || linkQ.size() != 0) && t < 500) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 500) failNow("packet_complete");
    @(posedge iClk);
    #1;
    checkOutput("addr_consumed", addrsUsed - used0, expAddrs);
    pktNum++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    iRst_n = 1'b0; iSop = 1'b0; iEop = 1'b0; iVld = 1'b0; iData = '0;
    iMmuRdy = 1'b1; iTagRdy = 1'b1;
    repeat (3) @(negedge iClk);
    checkOutput("reset_outputs", allOut, 0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(negedge iClk);
    checkOutput("idle_rdy", oRdy, 1);

    // Stray words before any start-of-packet are swallowed.
    driveWord(32'hDEAD0001, 1'b0, 1'b0);
    driveWord(32'hDEAD0002, 1'b0, 1'b1);

    applyStimulus(3,   7'h23, 4'd0,  1'b0, 1,  1'b0, -1);
    applyStimulus(20,  7'h47, 4'd2,  1'b0, 3,  1'b0, 10);
    applyStimulus(8,   7'h12, 4'd0,  1'b0, 1,  1'b0, -1);
    applyStimulus(6,   7'h5A, 4'd0,  1'b0, 1,  1'b1, -1);
    applyStimulus(130, 7'h7F, 4'd15, 1'b1, 16, 1'b0, -1);

    // Abandon a packet with reset after five words, then send a clean one.
    ignoreMon = 1'b1;
    for (int k = 0; k < 5; k++) driveWord(wordOf(pktNum, k, 7'h11), k == 0, 1'b0);
    iRst_n = 1'b0;
    @(negedge iClk);
    checkOutput("reset_mid_outputs", allOut, 0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    ignoreMon = 1'b0;
    pktNum++;
    applyStimulus(3, 7'h31, 4'd0, 1'b0, 1, 1'b0, -1);

    repeat (5) @(negedge iClk);
    checkOutput("final_queues_empty", tagQ.size() + linkQ.size() + mmuQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
